data_island_scheduler: RTL and testbench
========================================

// Module: data_island_scheduler
// PURPOSE
//  Chooses the packet sent in each slot of an HDMI data island, one slot per 32 pixel clocks.
//  Sources are: audio sample packets, Audio Clock Regeneration (ACR), AVI InfoFrame, Audio InfoFrame and null.
//  Sits between the hdmi core's island timing and its packet assembler.
//  Tracks pending audio samples, the ACR interval and per-frame InfoFrame obligations.
// PARAMETERS
//  AUDIO_FIFO_DEPTH    8      max pending samples counted; must be >= SAMPLES_PER_PACKET
//  SAMPLES_PER_PACKET  4      max samples carried by one audio sample packet
//  AUDIO_URGENT        4      pending count at/above which audio outranks every other source
//  ACR_INTERVAL        25200  pixel clocks between ACR requests (1 kHz at 25.2 MHz)
//  MAX_SLOTS           18     max packets per island (HDMI limit)
// PORTS
//  clk_pixel           in   1   pixel clock
//  reset_n             in   1   asynchronous, active-low reset
//  frame_start         in   1   one-cycle pulse at the vsync leading edge
//  island_start        in   1   one-cycle pulse: a data island begins
//  island_slots        in   5   slots in this island (1..MAX_SLOTS); sampled on island_start
//  slot_req            in   1   one-cycle pulse: assembler needs the next packet
//  audio_sample_valid  in   1   one new stereo sample has been written to the core's sample store
//  pkt_valid           out  1   one-cycle pulse: pkt_type/pkt_samples valid
//  pkt_type            out  8   0x00 null, 0x01 ACR, 0x02 audio sample, 0x82 AVI, 0x84 audio InfoFrame
//  pkt_samples         out  3   samples consumed by this packet (audio only, else 0)
//  island_active       out  1   high from the cycle after island_start until slots are exhausted
//  audio_overflow      out  1   sticky: a sample arrived while the count was saturated
//  protocol_err        out  1   sticky: slot_req while idle or with no slots left
// BEHAVIOUR
//  Reset (async assert, sync deassert) values:
//   - all outputs 0, state IDLE, counters 0
//   - avi_pending = 1 and ainfo_pending = 1, so both InfoFrames go out in the first frame
//   - acr_pending = 0
//  States: IDLE -> ISLAND on island_start (slots_left <= island_slots).
//   - island_slots == 0 stays IDLE and sets protocol_err.
//   - ISLAND -> IDLE in the cycle a grant takes slots_left to 0.
//  Grant timing:
//   - slot_req in ISLAND: exactly one grant, registered.
//   - pkt_valid rises the cycle after slot_req (latency 1); pkt_type/pkt_samples are held until the next grant.
//  Priority, evaluated on the slot_req cycle with the pre-update counts:
//   1. audio, if pending >= AUDIO_URGENT
//   2. ACR
//   3. AVI
//   4. audio InfoFrame
//   5. audio, if pending >= 1
//   6. null
//  Audio grant: pkt_samples = min(pending, SAMPLES_PER_PACKET); pending decreases by that amount.
//  Sample count update in one cycle:
//   - pending_next = pending + valid - popped, saturating at AUDIO_FIFO_DEPTH.
//   - A pop and an arrival in the same cycle are both honoured.
//   - Arrival at saturation (with no pop) sets audio_overflow; the count stays at AUDIO_FIFO_DEPTH.
//  ACR timer: free-running 0..ACR_INTERVAL-1; the wrap sets acr_pending.
//   - The ACR grant clears acr_pending.
//   - Wrap on the same cycle as the ACR grant: acr_pending stays 1 (the new request wins).
//  frame_start sets avi_pending and ainfo_pending.
//   - Already-set flags stay set; no double send.
//   - frame_start on the same cycle as the matching grant: the flag stays 1.
//   - frame_start during an island: the flags are eligible from the next slot_req.
//  slot_req in IDLE or with slots_left == 0: no grant, pkt_valid stays 0, protocol_err set.
//  island_start while already in ISLAND: slots_left is reloaded; pending flags are untouched.
//  Reset mid-island: returns immediately to the reset values above; nothing partial is emitted.
//  All width arithmetic is unsigned; pending uses $clog2(AUDIO_FIFO_DEPTH+1) bits.
// STRUCTURE
//  Package hdmi_pkt_pkg holds:
//   - the pkt_type localparams (PKT_NULL, PKT_ACR, PKT_AUDIO, PKT_AVI, PKT_AINFO)
//   - the state enum {IDLE, ISLAND}
//  Single flat module; no sub-module. The ACR timer, flags and priority mux share one always_ff block plus one always_comb selector.
// TESTING
//  1. Reset, island_start with island_slots=3, then 3 slot_req:
//     - grants are 0x82, 0x84, 0x00, each pkt_valid one cycle after its slot_req
//     - island_active falls after the 3rd grant
//  2. 6 samples pending, ACR pending, slot_req:
//     - grants are 0x02 (pkt_samples=4), then 0x01, then 0x02 (pkt_samples=2)
//  3. 2 samples pending plus ACR pending:
//     - grants are 0x01 then 0x02 (pkt_samples=2)
//  4. 9 samples with no slots:
//     - count saturates at 8 and audio_overflow=1
//     - arrival in the same cycle as a 4-sample grant leaves pending at 5
//  5. slot_req in IDLE:
//     - no pkt_valid and protocol_err=1
//     - frame_start on an AVI grant cycle: AVI is sent again at the next slot
//  6. Assert reset_n=0 mid-island with grants outstanding:
//     - outputs go to 0 asynchronously
//     - the first island after release sends AVI first

Source files
------------

// File: rtl/hdmi_pkt_pkg.sv
// Packet type codes and scheduler state shared by the HDMI data island logic.
// Imported by the island scheduler and the packet assembler.
package hdmi_pkt_pkg;

  localparam logic [7:0] PKT_NULL  = 8'h00;
  localparam logic [7:0] PKT_ACR   = 8'h01;
  localparam logic [7:0] PKT_AUDIO = 8'h02;
  localparam logic [7:0] PKT_AVI   = 8'h82;
  localparam logic [7:0] PKT_AINFO = 8'h84;

  typedef enum logic {
    IDLE,
    ISLAND
  } state_t;

endpackage

// File: rtl/data_island_scheduler.sv
// Picks the packet for each data island slot: audio, ACR, AVI, audio
// InfoFrame or null, tracking pending samples, ACR timer and frame flags.
module data_island_scheduler
  import hdmi_pkt_pkg::*;
#(
  parameter int AUDIO_FIFO_DEPTH   = 8,
  parameter int SAMPLES_PER_PACKET = 4,
  parameter int AUDIO_URGENT       = 4,
  parameter int ACR_INTERVAL       = 25200,
  parameter int MAX_SLOTS          = 18
) (
  input  logic       clk_pixel,
  input  logic       reset_n,
  input  logic       frame_start,
  input  logic       island_start,
  input  logic [4:0] island_slots,
  input  logic       slot_req,
  input  logic       audio_sample_valid,
  output logic       pkt_valid,
  output logic [7:0] pkt_type,
  output logic [2:0] pkt_samples,
  output logic       island_active,
  output logic       audio_overflow,
  output logic       protocol_err
);

  localparam int PW = $clog2(AUDIO_FIFO_DEPTH + 1);
  localparam int TW = (ACR_INTERVAL > 1) ? $clog2(ACR_INTERVAL) : 1;

  localparam logic [PW-1:0] DEPTH_V = PW'(AUDIO_FIFO_DEPTH);
  localparam logic [PW-1:0] SPP_V   = PW'(SAMPLES_PER_PACKET);
  localparam logic [PW-1:0] URG_V   = PW'(AUDIO_URGENT);
  localparam logic [TW-1:0] TLAST   = TW'(ACR_INTERVAL - 1);
  localparam logic [4:0]    MAXS_V  = 5'(MAX_SLOTS);

  state_t state_q;
  state_t state_d;

  logic [4:0]    slots_left;
  logic [4:0]    slots_load;
  logic [PW-1:0] pending;
  logic [PW-1:0] take;
  logic [PW-1:0] pop;
  logic [PW:0]   pend_sum;
  logic [TW-1:0] timer;
  logic          wrap;
  logic          acr_pending;
  logic          avi_pending;
  logic          ainfo_pending;
  logic          grant;
  logic          urgent;
  logic          sel_audio;
  logic          sel_acr;
  logic          sel_avi;
  logic          sel_ainfo;
  logic [7:0]    sel_type;

  assign grant = slot_req && (state_q == ISLAND)
              && (slots_left != 5'd0);
  assign wrap  = (timer == TLAST);

  // Oversized requests are clipped to the HDMI per-island limit.
  assign slots_load = (island_slots > MAXS_V) ? MAXS_V
                                              : island_slots;

  always_comb begin
    urgent    = (pending >= URG_V);
    take      = (pending >= SPP_V) ? SPP_V : pending;
    sel_acr   = !urgent && acr_pending;
    sel_avi   = !urgent && !acr_pending && avi_pending;
    sel_ainfo = !urgent && !acr_pending && !avi_pending
             && ainfo_pending;
    sel_audio = urgent || (!acr_pending && !avi_pending
             && !ainfo_pending && (pending != '0));
    sel_type  = PKT_NULL;
    pop       = '0;
    unique case (1'b1)
      sel_audio: begin
        sel_type = PKT_AUDIO;
        pop      = grant ? take : '0;
      end
      sel_acr:   sel_type = PKT_ACR;
      sel_avi:   sel_type = PKT_AVI;
      sel_ainfo: sel_type = PKT_AINFO;
      default:   sel_type = PKT_NULL;
    endcase
    pend_sum = {1'b0, pending}
             + {{PW{1'b0}}, audio_sample_valid}
             - {1'b0, pop};
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (grant && slots_left == 5'd1) state_d = IDLE;
    if (island_start) begin
      state_d = (island_slots != 5'd0) ? ISLAND : IDLE;
    end
  end

  always_comb begin
    island_active = (state_q == ISLAND);
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      timer          <= '0;
      acr_pending    <= 1'b0;
      avi_pending    <= 1'b1;
      ainfo_pending  <= 1'b1;
      pending        <= '0;
      slots_left     <= 5'd0;
      pkt_valid      <= 1'b0;
      pkt_type       <= PKT_NULL;
      pkt_samples    <= 3'd0;
      audio_overflow <= 1'b0;
      protocol_err   <= 1'b0;
    end else begin
      timer <= wrap ? '0 : timer + 1'b1;
      // A new request or frame obligation beats a same-cycle grant.
      acr_pending   <= wrap
                    | (acr_pending & ~(grant & sel_acr));
      avi_pending   <= frame_start
                    | (avi_pending & ~(grant & sel_avi));
      ainfo_pending <= frame_start
                    | (ainfo_pending & ~(grant & sel_ainfo));
      pending <= (pend_sum > {1'b0, DEPTH_V}) ? DEPTH_V
                                              : pend_sum[PW-1:0];
      if (audio_sample_valid && pending == DEPTH_V
          && pop == '0) begin
        audio_overflow <= 1'b1;
      end
      if ((slot_req && !grant)
          || (island_start && island_slots == 5'd0)) begin
        protocol_err <= 1'b1;
      end
      pkt_valid <= grant;
      if (grant) begin
        pkt_type    <= sel_type;
        pkt_samples <= sel_audio ? 3'(take) : 3'd0;
      end
      if (island_start)  slots_left <= slots_load;
      else if (grant)    slots_left <= slots_left - 5'd1;
    end
  end

endmodule

// File: tb/tb_data_island_scheduler.sv
// Bench for data_island_scheduler: vector table, directed corner cases
// and random traffic against a slot-level reference model.
module tb_data_island_scheduler;

  localparam int INT   = 50;
  localparam int DEPTH = 8;
  localparam int SPP   = 4;
  localparam int URG   = 4;

  logic       clk_pixel = 1'b0;
  logic       reset_n = 1'b0;
  logic       frame_start = 1'b0;
  logic       island_start = 1'b0;
  logic [4:0] island_slots = 5'd0;
  logic       slot_req = 1'b0;
  logic       audio_sample_valid = 1'b0;
  logic       pkt_valid;
  logic [7:0] pkt_type;
  logic [2:0] pkt_samples;
  logic       island_active;
  logic       audio_overflow;
  logic       protocol_err;

  data_island_scheduler #(
    .AUDIO_FIFO_DEPTH  (DEPTH),
    .SAMPLES_PER_PACKET(SPP),
    .AUDIO_URGENT      (URG),
    .ACR_INTERVAL      (INT),
    .MAX_SLOTS         (18)
  ) dut (
    .clk_pixel         (clk_pixel),
    .reset_n           (reset_n),
    .frame_start       (frame_start),
    .island_start      (island_start),
    .island_slots      (island_slots),
    .slot_req          (slot_req),
    .audio_sample_valid(audio_sample_valid),
    .pkt_valid         (pkt_valid),
    .pkt_type          (pkt_type),
    .pkt_samples       (pkt_samples),
    .island_active     (island_active),
    .audio_overflow    (audio_overflow),
    .protocol_err      (protocol_err)
  );

  always #5 clk_pixel = ~clk_pixel;

  int passed = 0;
  int total  = 0;

  int m_pend, m_slots, m_cyc, m_type, m_samples;
  bit m_island, m_acr, m_avi, m_ainfo, m_ovf, m_perr, m_valid;

  typedef struct {
    bit       fs;
    bit       is;
    int       sl;
    bit       sr;
    bit       av;
    bit       ev;
    bit [7:0] et;
    int       es;
    bit       ea;
  } vec_t;

  vec_t tbl[5];

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h",
                  name, act, exp);
  endtask

  task automatic model_reset();
    m_pend = 0; m_slots = 0; m_cyc = 0;
    m_island = 0; m_acr = 0; m_avi = 1; m_ainfo = 1;
    m_ovf = 0; m_perr = 0; m_valid = 0;
    m_type = 0; m_samples = 0;
  endtask

  // Slot-level behaviour: decide this cycle's grant from the rules,
  // then advance counts and flags.
  task automatic model_cycle(bit fs, bit is, int sl,
                             bit sr, bit av);
    bit g, wrap;
    int gt, pop;
    g = sr && m_island && (m_slots > 0);
    gt = -1;
    pop = 0;
    if (g) begin
      if (m_pend >= URG) gt = 8'h02;
      else if (m_acr) gt = 8'h01;
      else if (m_avi) gt = 8'h82;
      else if (m_ainfo) gt = 8'h84;
      else if (m_pend >= 1) gt = 8'h02;
      else gt = 8'h00;
      if (gt == 8'h02) pop = (m_pend < SPP) ? m_pend : SPP;
      m_type = gt;
      m_samples = pop;
    end
    m_valid = g;
    if (sr && !g) m_perr = 1;
    if (is && sl == 0) m_perr = 1;
    wrap = (m_cyc % INT) == INT - 1;
    m_cyc++;
    m_acr = wrap || (m_acr && gt != 8'h01);
    m_avi = fs || (m_avi && gt != 8'h82);
    m_ainfo = fs || (m_ainfo && gt != 8'h84);
    if (av && m_pend == DEPTH && pop == 0) m_ovf = 1;
    m_pend = m_pend + int'(av) - pop;
    if (m_pend > DEPTH) m_pend = DEPTH;
    if (g) begin
      m_slots--;
      if (m_slots == 0) m_island = 0;
    end
    if (is) begin
      m_slots = sl;
      m_island = (sl != 0);
    end
  endtask

  task automatic step(bit fs, bit is, int sl, bit sr, bit av);
    frame_start = fs;
    island_start = is;
    island_slots = 5'(sl);
    slot_req = sr;
    audio_sample_valid = av;
    @(posedge clk_pixel);
    model_cycle(fs, is, sl, sr, av);
    #1;
    check("cycle", {pkt_valid, pkt_type, pkt_samples,
                    island_active, audio_overflow, protocol_err},
          {m_valid, 8'(m_type), 3'(m_samples),
           m_island, m_ovf, m_perr});
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  task automatic wait_acr();
    for (int i = 0; i < 2 * INT && !m_acr; i++) idle(1);
  endtask

  task automatic drain();
    step(0, 1, 18, 0, 0);
    for (int i = 0; i < 18 && m_island; i++) step(0, 0, 0, 1, 0);
  endtask

  initial begin
    tbl[0] = '{0, 1, 3, 0, 0, 0, 8'h00, 0, 1};
    tbl[1] = '{0, 0, 0, 1, 0, 1, 8'h82, 0, 1};
    tbl[2] = '{0, 0, 0, 1, 0, 1, 8'h84, 0, 1};
    tbl[3] = '{0, 0, 0, 1, 0, 1, 8'h00, 0, 0};
    tbl[4] = '{0, 0, 0, 0, 0, 0, 8'h00, 0, 0};

    model_reset();
    #1;
    check("reset_outputs", {pkt_valid, pkt_type, pkt_samples,
          island_active, audio_overflow, protocol_err}, 32'h0);
    #11;
    reset_n = 1'b1;
    model_reset();

    // Test 1: InfoFrames first, then null, island closes.
    for (int i = 0; i < 5; i++) begin
      step(tbl[i].fs, tbl[i].is, tbl[i].sl, tbl[i].sr, tbl[i].av);
      check($sformatf("tbl%0d", i),
            {pkt_valid, pkt_type, pkt_samples, island_active},
            {tbl[i].ev, tbl[i].et, 3'(tbl[i].es), tbl[i].ea});
    end

    // Test 2: 6 samples + ACR -> audio 4, ACR, audio 2.
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1);
    wait_acr();
    step(0, 1, 3, 0, 0);
    step(0, 0, 0, 1, 0);
    check("t2_audio4", {pkt_valid, pkt_type, pkt_samples},
          {1'b1, 8'h02, 3'd4});
    step(0, 0, 0, 1, 0);
    check("t2_acr", {pkt_valid, pkt_type}, {1'b1, 8'h01});
    step(0, 0, 0, 1, 0);
    check("t2_audio2", {pkt_valid, pkt_type, pkt_samples},
          {1'b1, 8'h02, 3'd2});
    check("t2_active", island_active, 0);

    // Test 3: 2 samples + ACR -> ACR then audio 2.
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    wait_acr();
    step(0, 1, 2, 0, 0);
    step(0, 0, 0, 1, 0);
    check("t3_acr", {pkt_valid, pkt_type}, {1'b1, 8'h01});
    step(0, 0, 0, 1, 0);
    check("t3_audio2", {pkt_valid, pkt_type, pkt_samples},
          {1'b1, 8'h02, 3'd2});

    // Test 4: saturation, overflow, pop with arrival.
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 1);
    check("t4_no_ovf_at_8", audio_overflow, 0);
    step(0, 0, 0, 0, 1);
    check("t4_ovf", audio_overflow, 1);
    step(0, 1, 3, 0, 0);
    step(0, 0, 0, 1, 1);
    check("t4_pop4_arrive", {pkt_type, pkt_samples},
          {8'h02, 3'd4});
    step(0, 0, 0, 1, 0);
    check("t4_second4", {pkt_type, pkt_samples}, {8'h02, 3'd4});
    step(0, 0, 0, 1, 0);

    // Test 5: slot_req while idle; frame_start on AVI grant.
    step(0, 0, 0, 1, 0);
    check("t5_idle_req", {pkt_valid, protocol_err}, {1'b0, 1'b1});
    wait_acr();
    drain();
    step(1, 0, 0, 0, 0);
    step(0, 1, 3, 0, 0);
    step(1, 0, 0, 1, 0);
    check("t5_avi1", {pkt_valid, pkt_type}, {1'b1, 8'h82});
    step(0, 0, 0, 1, 0);
    check("t5_avi2", {pkt_valid, pkt_type}, {1'b1, 8'h82});
    step(0, 0, 0, 1, 0);
    check("t5_ainfo", {pkt_valid, pkt_type}, {1'b1, 8'h84});

    // Test 6: reset mid-island.
    step(0, 1, 4, 0, 1);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    #3;
    reset_n = 1'b0;
    #1;
    check("t6_async_reset", {pkt_valid, pkt_type, pkt_samples,
          island_active, audio_overflow, protocol_err}, 32'h0);
    #10;
    reset_n = 1'b1;
    model_reset();
    step(0, 1, 2, 0, 0);
    step(0, 0, 0, 1, 0);
    check("t6_avi_first", {pkt_valid, pkt_type}, {1'b1, 8'h82});

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      bit fs, is, sr, av;
      int sl;
      fs = ($urandom_range(0, 99) < 2);
      is = ($urandom_range(0, 99) < 6);
      sl = ($urandom_range(0, 19) == 0) ? 0 : $urandom_range(1, 18);
      sr = ($urandom_range(0, 99) < 45);
      av = ($urandom_range(0, 99) < 30);
      step(fs, is, sl, sr, av);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
